sdram_checkmod: RTL and testbench

//  Upstream traffic master for sdram_basemod: on iStart writes BLOCKS bursts of BURST

---
 rtl/sdram_check_pkg.sv | 24 ++
 rtl/sdram_check_addrgen.sv | 57 +++++
 rtl/sdram_checkmod.sv | 179 +++++++++++++++++
 tb/tb_sdram_checkmod.sv | 363 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sdram_check_pkg.sv
// Shared types and helpers for the SDRAM write/read-back checker.
package sdram_check_pkg;

    localparam int ADDR_W = 24;
    localparam int DATA_W = 16;

    typedef enum logic [2:0] {
        stIdle,
        stFill,
        stWcall,
        stRstart,
        stRcall,
        stDrain,
        stPass,
        stFail
    } checkState_e;

    // Test pattern: low address bits scrambled by the seed.
    function automatic logic [DATA_W-1:0] pattern(input logic [ADDR_W-1:0] addr,
                                                  input logic [DATA_W-1:0] seed);
        return addr[DATA_W-1:0] ^ seed;
    endfunction

endpackage

// File: rtl/sdram_check_addrgen.sv
// Block and word counters for the checker.
// Produces the burst start address, the current word address and the pattern word
// expected at that address.
module sdram_check_addrgen
    import sdram_check_pkg::*;
#(
    parameter int                BURST     = 4,
    parameter int                BLOCKS    = 16,
    parameter logic [ADDR_W-1:0] BASE_ADDR = '0,
    parameter logic [DATA_W-1:0] SEED      = 16'hA5A5
) (
    input  logic              CLOCK,
    input  logic              RESET,
    input  logic              clear,
    input  logic              nextWord,
    input  logic              nextBlock,
    output logic [ADDR_W-1:0] blockAddr,
    output logic [ADDR_W-1:0] wordAddr,
    output logic [DATA_W-1:0] expWord,
    output logic              lastWord,
    output logic              wordEnd,
    output logic              lastBlock
);

    localparam int BLK_W  = $clog2(BLOCKS + 1);
    localparam int WORD_W = $clog2(BURST + 1);
    localparam logic [ADDR_W-1:0] BURST_A = ADDR_W'(BURST);

    logic [BLK_W-1:0]  blk;
    logic [WORD_W-1:0] word;

    // Word counter runs one past the burst so the drain phase has a tail cycle for
    // the final compare; stepping to the next block rewinds it and wraps blk after
    // the last block so the read phase restarts at block 0.
    always_ff @(posedge CLOCK or negedge RESET) begin
        if (!RESET) begin
            blk  <= '0;
            word <= '0;
        end else if (clear) begin
            blk  <= '0;
            word <= '0;
        end else if (nextBlock) begin
            word <= '0;
            blk  <= lastBlock ? '0 : blk + 1'b1;
        end else if (nextWord) begin
            word <= word + 1'b1;
        end
    end

    assign blockAddr = BASE_ADDR + ADDR_W'(blk) * BURST_A;
    assign wordAddr  = blockAddr + ADDR_W'(word);
    assign expWord   = pattern(wordAddr, SEED);
    assign lastWord  = (word == WORD_W'(BURST - 1));
    assign wordEnd   = (word == WORD_W'(BURST));
    assign lastBlock = (blk == BLK_W'(BLOCKS - 1));

endmodule

// File: rtl/sdram_checkmod.sv
// Traffic master for sdram_basemod: writes address-derived bursts, reads them back
// and compares every word, reporting pass or the first failing address.
module sdram_checkmod
    import sdram_check_pkg::*;
#(
    parameter int                BURST     = 4,
    parameter int                BLOCKS    = 16,
    parameter logic [ADDR_W-1:0] BASE_ADDR = 24'h0,
    parameter logic [DATA_W-1:0] SEED      = 16'hA5A5
) (
    input  logic              CLOCK,
    input  logic              RESET,
    input  logic              iStart,
    output logic              oBusy,
    output logic              oPass,
    output logic              oFail,
    output logic [ADDR_W-1:0] oErrAddr,
    output logic [1:0]        oEn,
    output logic [ADDR_W-1:0] oAddr,
    output logic [DATA_W-1:0] oData,
    input  logic [DATA_W-1:0] iData,
    output logic [1:0]        oCall,
    input  logic [1:0]        iDone
);

    checkState_e       state;
    checkState_e       nextState;
    logic              clear;
    logic              nextWord;
    logic              nextBlock;
    logic [ADDR_W-1:0] blockAddr;
    logic [ADDR_W-1:0] wordAddr;
    logic [DATA_W-1:0] expWord;
    logic              lastWord;
    logic              wordEnd;
    logic              lastBlock;
    logic              cmpValid;
    logic [DATA_W-1:0] cmpExp;
    logic [ADDR_W-1:0] cmpAddr;
    logic              mismatch;

    sdram_check_addrgen #(
        .BURST     (BURST),
        .BLOCKS    (BLOCKS),
        .BASE_ADDR (BASE_ADDR),
        .SEED      (SEED)
    ) addrGen (
        .CLOCK     (CLOCK),
        .RESET     (RESET),
        .clear     (clear),
        .nextWord  (nextWord),
        .nextBlock (nextBlock),
        .blockAddr (blockAddr),
        .wordAddr  (wordAddr),
        .expWord   (expWord),
        .lastWord  (lastWord),
        .wordEnd   (wordEnd),
        .lastBlock (lastBlock)
    );

    // Read data arrives one cycle after the pop, so only a registered compare is valid.
    assign mismatch = (state == stDrain) && cmpValid && (iData != cmpExp);

    // State register; reset drops every state-decoded output at once.
    always_ff @(posedge CLOCK or negedge RESET) begin
        if (!RESET) begin
            state <= stIdle;
        end else begin
            state <= nextState;
        end
    end

    // Next-state logic and FIFO/call outputs, all decoded from the current state.
    always_comb begin
        nextState = state;
        clear     = 1'b0;
        nextWord  = 1'b0;
        nextBlock = 1'b0;
        oEn       = 2'b00;
        oCall     = 2'b00;
        oData     = '0;
        oAddr     = '0;
        case (state)
            stIdle: begin
                if (iStart) begin
                    clear     = 1'b1;
                    nextState = stFill;
                end
            end
            stFill: begin
                oAddr    = blockAddr;
                oEn[1]   = 1'b1;
                oData    = expWord;
                nextWord = 1'b1;
                if (lastWord) begin
                    nextState = stWcall;
                end
            end
            stWcall: begin
                oAddr    = blockAddr;
                oCall[1] = 1'b1;
                if (iDone[1]) begin
                    nextBlock = 1'b1;
                    nextState = lastBlock ? stRstart : stFill;
                end
            end
            stRstart: begin
                oAddr     = blockAddr;
                nextState = stRcall;
            end
            stRcall: begin
                oAddr    = blockAddr;
                oCall[0] = 1'b1;
                if (iDone[0]) begin
                    nextState = stDrain;
                end
            end
            stDrain: begin
                oAddr = blockAddr;
                if (!wordEnd) begin
                    oEn[0]   = 1'b1;
                    nextWord = 1'b1;
                end
                if (mismatch) begin
                    nextState = stFail;
                end else if (wordEnd) begin
                    nextBlock = 1'b1;
                    nextState = lastBlock ? stPass : stRcall;
                end
            end
            stPass: begin
                nextState = stIdle;
            end
            stFail: begin
                nextState = stIdle;
            end
            default: begin
                nextState = stIdle;
            end
        endcase
    end

    // Compare pipeline: remember what each popped word should be and where it lives.
    always_ff @(posedge CLOCK or negedge RESET) begin
        if (!RESET) begin
            cmpValid <= 1'b0;
            cmpExp   <= '0;
            cmpAddr  <= '0;
        end else begin
            cmpValid <= oEn[0];
            cmpExp   <= expWord;
            cmpAddr  <= wordAddr;
        end
    end

    // Sticky run status: cleared on an accepted start, set by the first mismatch or
    // by the last word of the last block comparing equal.
    always_ff @(posedge CLOCK or negedge RESET) begin
        if (!RESET) begin
            oBusy    <= 1'b0;
            oPass    <= 1'b0;
            oFail    <= 1'b0;
            oErrAddr <= '0;
        end else if ((state == stIdle) && iStart) begin
            oBusy    <= 1'b1;
            oPass    <= 1'b0;
            oFail    <= 1'b0;
            oErrAddr <= '0;
        end else if (mismatch) begin
            oFail    <= 1'b1;
            oErrAddr <= cmpAddr;
            oBusy    <= 1'b0;
        end else if ((state == stDrain) && wordEnd && lastBlock) begin
            oPass <= 1'b1;
            oBusy <= 1'b0;
        end
    end

endmodule

// File: tb/tb_sdram_checkmod.sv
// Bench for sdram_checkmod: models sdram_basemod as two FIFOs plus a sparse memory
// and checks the checker's traffic and verdicts against values derived from the rules.
module tb_sdram_checkmod;

    logic CLOCK = 1'b0;
    logic RESET = 1'b0;

    always #5 CLOCK = ~CLOCK;

    logic        start0 = 1'b0;
    logic        start1 = 1'b0;
    logic        busy0, pass0, fail0, busy1, pass1, fail1;
    logic [23:0] errAddr0, errAddr1, addr0, addr1;
    logic [1:0]  en0, en1, call0, call1, done0, done1;
    logic [15:0] data0, data1;
    logic [15:0] rdData = 16'h0;
    logic [1:0]  modelDone = 2'b00;
    logic [1:0]  injDone = 2'b00;
    bit          sel = 1'b0;

    logic        curBusy, curPass, curFail;
    logic [23:0] curErr, curAddr;
    logic [1:0]  curEn, curCall;
    logic [15:0] curData;

    // model state and configuration
    logic [15:0] wq[$];
    logic [15:0] rq[$];
    logic [15:0] mem[int];
    logic [15:0] pushLog[4];
    int          pushCount = 0;
    int          wrCalls = 0;
    int          rdCalls = 0;
    int          runLen = 0;
    int          wrTimer = 0;
    int          rdTimer = 0;
    bit          wrBusy = 1'b0;
    bit          rdBusy = 1'b0;
    logic [23:0] wrAddr = '0;
    logic [23:0] rdAddr = '0;
    logic [23:0] lastWrAddr = '0;
    logic [23:0] lastRdAddr = '0;
    logic [15:0] pendWord = '0;
    bit          pendValid = 1'b0;
    bit          holdDone = 1'b0;
    bit          corruptEn = 1'b0;
    logic [23:0] corruptAddr = '0;
    logic [15:0] corruptMask = 16'h0001;
    int          doneLat = 10;
    logic [23:0] expBase = '0;
    logic [15:0] w;
    logic [23:0] a;

    int compareCount = 0;
    int mismatchCount = 0;

    sdram_checkmod dut0 (
        .CLOCK(CLOCK), .RESET(RESET), .iStart(start0),
        .oBusy(busy0), .oPass(pass0), .oFail(fail0), .oErrAddr(errAddr0),
        .oEn(en0), .oAddr(addr0), .oData(data0), .iData(rdData),
        .oCall(call0), .iDone(done0)
    );

    sdram_checkmod #(.BASE_ADDR(24'hFFFFC0), .BLOCKS(16)) dut1 (
        .CLOCK(CLOCK), .RESET(RESET), .iStart(start1),
        .oBusy(busy1), .oPass(pass1), .oFail(fail1), .oErrAddr(errAddr1),
        .oEn(en1), .oAddr(addr1), .oData(data1), .iData(rdData),
        .oCall(call1), .iDone(done1)
    );

    assign curBusy = sel ? busy1 : busy0;
    assign curPass = sel ? pass1 : pass0;
    assign curFail = sel ? fail1 : fail0;
    assign curErr  = sel ? errAddr1 : errAddr0;
    assign curAddr = sel ? addr1 : addr0;
    assign curEn   = sel ? en1 : en0;
    assign curCall = sel ? call1 : call0;
    assign curData = sel ? data1 : data0;
    assign done0   = sel ? 2'b00 : (modelDone | injDone);
    assign done1   = sel ? (modelDone | injDone) : 2'b00;

    function automatic logic [15:0] tbWord(input logic [23:0] addr);
        return addr[15:0] ^ 16'hA5A5;
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        compareCount++;
        if (observed !== expected) begin
            mismatchCount++;
            $display("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Base-module model: write FIFO, memory, read FIFO with one-cycle read latency,
    // done pulses a fixed latency after each call. Runs on the falling edge.
    always @(negedge CLOCK or negedge RESET) begin
        if (!RESET) begin
            wq.delete();
            rq.delete();
            mem.delete();
            pushCount = 0;
            wrCalls = 0;
            rdCalls = 0;
            runLen = 0;
            wrBusy = 1'b0;
            rdBusy = 1'b0;
            wrTimer = 0;
            rdTimer = 0;
            pendValid = 1'b0;
            modelDone = 2'b00;
            rdData = 16'h0;
        end else begin
            modelDone = 2'b00;
            if (pendValid) rdData = pendWord;
            pendValid = 1'b0;

            if (curCall != 2'b00)
                checkOutput("callExclusive", 32'(curCall == 2'b11), 32'd0);

            if (curEn[1]) begin
                if (pushCount < 4) pushLog[pushCount] = curData;
                checkOutput("pushData", 32'(curData), 32'(tbWord(expBase + 24'(pushCount))));
                wq.push_back(curData);
                pushCount++;
                runLen++;
            end else if (runLen != 0) begin
                checkOutput("fillLen", 32'(runLen), 32'd4);
                runLen = 0;
            end

            if (curEn[0]) begin
                if (rq.size() == 0) begin
                    checkOutput("readFifoEmpty", 32'd1, 32'd0);
                    pendWord = 16'h0;
                end else begin
                    pendWord = rq.pop_front();
                end
                pendValid = 1'b1;
            end

            if (wrBusy) begin
                if (wrTimer > 0) wrTimer--;
                if (wrTimer == 0 && !holdDone) begin
                    checkOutput("wrAddrHold", 32'(curAddr), 32'(wrAddr));
                    for (int i = 0; i < 4; i++) begin
                        a = wrAddr + 24'(i);
                        if (wq.size() == 0) begin
                            checkOutput("writeFifoEmpty", 32'd1, 32'd0);
                            w = 16'h0;
                        end else begin
                            w = wq.pop_front();
                        end
                        if (corruptEn && a == corruptAddr) w = w ^ corruptMask;
                        mem[int'(a)] = w;
                    end
                    modelDone[1] = 1'b1;
                    wrBusy = 1'b0;
                end
            end else if (curCall[1]) begin
                wrBusy = 1'b1;
                wrTimer = doneLat;
                wrAddr = curAddr;
                lastWrAddr = curAddr;
                checkOutput("wrCallAddr", 32'(curAddr), 32'(expBase + 24'(4 * wrCalls)));
                wrCalls++;
            end

            if (rdBusy) begin
                if (rdTimer > 0) rdTimer--;
                if (rdTimer == 0 && !holdDone) begin
                    checkOutput("rdAddrHold", 32'(curAddr), 32'(rdAddr));
                    for (int i = 0; i < 4; i++) begin
                        a = rdAddr + 24'(i);
                        rq.push_back(mem.exists(int'(a)) ? mem[int'(a)] : 16'h0);
                    end
                    modelDone[0] = 1'b1;
                    rdBusy = 1'b0;
                end
            end else if (curCall[0]) begin
                rdBusy = 1'b1;
                rdTimer = doneLat;
                rdAddr = curAddr;
                lastRdAddr = curAddr;
                checkOutput("rdCallAddr", 32'(curAddr), 32'(expBase + 24'(4 * rdCalls)));
                rdCalls++;
            end
        end
    end

    task automatic doReset();
        RESET = 1'b0;
        repeat (3) @(negedge CLOCK);
        RESET = 1'b1;
        @(negedge CLOCK);
    endtask

    // One-cycle start pulse to the selected checker.
    task automatic applyStimulus(input bit which);
        @(negedge CLOCK);
        if (which) start1 = 1'b1; else start0 = 1'b1;
        @(negedge CLOCK);
        start0 = 1'b0;
        start1 = 1'b0;
    endtask

    task automatic waitResult(input int budget);
        int n = 0;
        while (!(curPass || curFail) && n < budget) begin
            @(negedge CLOCK);
            n++;
        end
        if (n >= budget) checkOutput("resultTimeout", 32'd1, 32'd0);
        repeat (5) @(negedge CLOCK);
    endtask

    task automatic waitCall(input logic [1:0] target, input int budget);
        int n = 0;
        while (curCall !== target && n < budget) begin
            @(negedge CLOCK);
            n++;
        end
        if (n >= budget) checkOutput("callTimeout", 32'd1, 32'd0);
    endtask

    task automatic checkIdleOutputs(input string tag);
        checkOutput({tag, ".busy"}, 32'(busy0), 32'd0);
        checkOutput({tag, ".pass"}, 32'(pass0), 32'd0);
        checkOutput({tag, ".fail"}, 32'(fail0), 32'd0);
        checkOutput({tag, ".errAddr"}, 32'(errAddr0), 32'd0);
        checkOutput({tag, ".en"}, 32'(en0), 32'd0);
        checkOutput({tag, ".addr"}, 32'(addr0), 32'd0);
        checkOutput({tag, ".data"}, 32'(data0), 32'd0);
        checkOutput({tag, ".call"}, 32'(call0), 32'd0);
        checkOutput({tag, ".busy1"}, 32'(busy1), 32'd0);
    endtask

    task automatic checkPassRun(input string tag);
        checkOutput({tag, ".pass"}, 32'(curPass), 32'd1);
        checkOutput({tag, ".fail"}, 32'(curFail), 32'd0);
        checkOutput({tag, ".busy"}, 32'(curBusy), 32'd0);
        checkOutput({tag, ".pushes"}, 32'(pushCount), 32'd64);
        checkOutput({tag, ".wrCalls"}, 32'(wrCalls), 32'd16);
        checkOutput({tag, ".rdCalls"}, 32'(rdCalls), 32'd16);
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        // reset state and a clean default run
        doReset();
        checkIdleOutputs("reset");
        applyStimulus(0);
        waitResult(4000);
        checkPassRun("basic");

        // corrupted word at 0x2A
        corruptEn = 1'b1;
        corruptAddr = 24'h00002A;
        corruptMask = 16'h0001;
        doReset();
        applyStimulus(0);
        waitResult(4000);
        repeat (30) @(negedge CLOCK);
        checkOutput("corrupt.fail", 32'(fail0), 32'd1);
        checkOutput("corrupt.pass", 32'(pass0), 32'd0);
        checkOutput("corrupt.busy", 32'(busy0), 32'd0);
        checkOutput("corrupt.errAddr", 32'(errAddr0), 32'h00002A);
        checkOutput("corrupt.rdCalls", 32'(rdCalls), 32'd11);
        corruptEn = 1'b0;

        // asynchronous reset in the middle of block 5 read call
        doReset();
        applyStimulus(0);
        begin
            int n = 0;
            while (rdCalls < 6 && n < 4000) begin
                @(negedge CLOCK);
                n++;
            end
            if (n >= 4000) checkOutput("abortTimeout", 32'd1, 32'd0);
        end
        checkOutput("abort.callBefore", 32'(call0), 32'd1);
        #2 RESET = 1'b0;
        #1 checkIdleOutputs("abort");
        repeat (2) @(negedge CLOCK);
        RESET = 1'b1;
        @(negedge CLOCK);
        applyStimulus(0);
        waitResult(4000);
        checkPassRun("afterAbort");

        // spurious start and wrong done bit during a write call
        doReset();
        applyStimulus(0);
        waitCall(2'b10, 200);
        injDone = 2'b01;
        start0 = 1'b1;
        @(negedge CLOCK);
        injDone = 2'b00;
        start0 = 1'b0;
        checkOutput("spurious.call", 32'(call0), 32'h2);
        checkOutput("spurious.busy", 32'(busy0), 32'd1);
        waitResult(4000);
        checkPassRun("spurious");

        // stalled write call: block 0 data and a call that never completes
        holdDone = 1'b1;
        doReset();
        applyStimulus(0);
        waitCall(2'b10, 200);
        repeat (30) @(negedge CLOCK);
        checkOutput("stall.call", 32'(call0), 32'h2);
        checkOutput("stall.busy", 32'(busy0), 32'd1);
        checkOutput("stall.pushes", 32'(pushCount), 32'd4);
        checkOutput("stall.word0", 32'(pushLog[0]), 32'hA5A5);
        checkOutput("stall.word1", 32'(pushLog[1]), 32'hA5A4);
        checkOutput("stall.word2", 32'(pushLog[2]), 32'hA5A7);
        checkOutput("stall.word3", 32'(pushLog[3]), 32'hA5A6);
        holdDone = 1'b0;

        // top-of-memory base address
        sel = 1'b1;
        expBase = 24'hFFFFC0;
        doReset();
        applyStimulus(1);
        waitResult(4000);
        checkPassRun("topAddr");
        checkOutput("topAddr.lastWr", 32'(lastWrAddr), 32'hFFFFFC);
        checkOutput("topAddr.lastRd", 32'(lastRdAddr), 32'hFFFFFC);
        sel = 1'b0;
        expBase = 24'h0;

        // randomized latency and corruption
        for (int r = 0; r < 4; r++) begin
            doneLat = int'($urandom_range(2, 12));
            corruptEn = 1'($urandom_range(0, 1));
            corruptAddr = 24'($urandom_range(0, 63));
            corruptMask = 16'(1 << $urandom_range(0, 15));
            doReset();
            applyStimulus(0);
            waitResult(5000);
            checkOutput("rand.pushes", 32'(pushCount), 32'd64);
            if (corruptEn) begin
                checkOutput("rand.fail", 32'(curFail), 32'd1);
                checkOutput("rand.pass", 32'(curPass), 32'd0);
                checkOutput("rand.errAddr", 32'(curErr), 32'(corruptAddr));
                checkOutput("rand.rdCalls", 32'(rdCalls), 32'(int'(corruptAddr) / 4 + 1));
            end else begin
                checkPassRun("rand");
            end
        end
        corruptEn = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, mismatchCount);
        $finish;
    end

endmodule
